// File: rtl/coeff_bank_loader_if.sv
// coeff_bank_loader_if: coefficient write channels, independent address and data valid/ready.
interface coeff_bank_loader_if #(parameter int AW = 32, parameter int DW = 32);
   logic [AW-1:0] filter_addr;
   logic          filter_addr_valid;
   logic          filter_addr_ready;
   logic [DW-1:0] filter_data;
   logic          filter_data_valid;
   logic          filter_data_ready;
   modport master (output filter_addr, filter_addr_valid, filter_data, filter_data_valid,
                   input  filter_addr_ready, filter_data_ready);
   modport slave  (input  filter_addr, filter_addr_valid, filter_data, filter_data_valid,
                   output filter_addr_ready, filter_data_ready);
endinterface

// File: rtl/coeff_bank_loader.sv
// coeff_bank_loader: double-buffered FIR coefficient store; shadow bank is loaded over
// the write channels and copied to the active bank on a vertical-sync rising edge.
module coeff_bank_loader #(
   parameter int TAPS        = 5,
   parameter int CW          = 16,
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int COMMIT_MODE = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     vs_i,
   coeff_bank_loader_if.slave       bus,
   output logic [TAPS*TAPS*CW-1:0]  coeff_o,
   output logic                     swap_o,
   output logic                     load_done_o,
   output logic                     addr_err_o
);
   localparam int N  = TAPS * TAPS;
   localparam int IW = N > 1 ? $clog2(N) : 1;
   localparam logic [1:0] EMPTY     = 2'b00;
   localparam logic [1:0] HAVE_ADDR = 2'b01;
   localparam logic [1:0] HAVE_DATA = 2'b10;
   localparam logic [1:0] BOTH      = 2'b11;

   logic [1:0]      state, state_n;
   logic [AW-1:0]   addr_q;
   logic [CW-1:0]   data_q;
   logic [N*CW-1:0] shadow;
   logic [N-1:0]    mask, mask_set;
   logic [IW-1:0]   idx;
   logic            vs_d, addr_hs, data_hs, commit, in_range, wr_en, swap;
   logic            unused_data;

   assign bus.filter_addr_ready = !state[0];
   assign bus.filter_data_ready = !state[1];
   assign addr_hs     = bus.filter_addr_valid & bus.filter_addr_ready;
   assign data_hs     = bus.filter_data_valid & bus.filter_data_ready;
   assign commit      = state == BOTH;
   assign in_range    = addr_q < AW'(N);
   assign wr_en       = commit & in_range;
   assign idx         = addr_q[IW-1:0];
   assign load_done_o = &mask;
   assign swap        = vs_i & !vs_d & (COMMIT_MODE == 0 || load_done_o);
   assign unused_data = ^bus.filter_data;

   // full flags double as the write FSM state; BOTH always commits and empties
   always_comb begin
      state_n  = commit ? EMPTY : state | {data_hs, addr_hs};
      mask_set = wr_en ? N'(1) << idx : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= EMPTY;
         addr_q     <= '0;
         data_q     <= '0;
         shadow     <= '0;
         coeff_o    <= '0;
         mask       <= '0;
         vs_d       <= 1'b0;
         swap_o     <= 1'b0;
         addr_err_o <= 1'b0;
      end else begin
         state  <= state_n;
         vs_d   <= vs_i;
         swap_o <= swap;
         if (addr_hs) addr_q <= bus.filter_addr;
         if (data_hs) data_q <= bus.filter_data[CW-1:0];
         if (wr_en) shadow[idx*CW +: CW] <= data_q;
         if (swap) coeff_o <= shadow;
         // a write on the swap edge counts toward the next load; errors set over clear
         mask       <= (swap ? '0 : mask) | mask_set;
         addr_err_o <= (addr_err_o & !swap) | (commit & !in_range);
      end
   end
endmodule
